// File: rtl/ram_resp.sv
// ram_resp -- single-port word memory behind a fixed-latency request/response
// handshake.
//
// A request (READ or WRITE) is accepted in IDLE. The FSM then waits LATENCY
// cycles in BUSY, commits the access on the last BUSY edge, and strobes
// o_ready for one cycle in RESP before returning to IDLE. Inputs are only
// sampled on the accept edge.
//
// Parameters:
//   DEPTH_LOG2  log2 of memory depth in 32-bit words
//   LATENCY     wait cycles spent in BUSY (1..15)
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset (storage is not cleared)
//   i_action  0 NONE, 1 READ, 2 WRITE, 3 reserved (treated as NONE)
//   i_addr    byte address; word index is i_addr[DEPTH_LOG2+1:2]
//   i_val     write data
//   o_val     registered read data, held between responses
//   o_ready   one-cycle response strobe
//   o_busy    high whenever the FSM is not IDLE
//   o_fault   misaligned-access flag, qualified by o_ready
//
// Build option:
//   RAM_RESP_ALIGN_CHECK_EN  when defined, a request whose address has
//   nonzero bits [1:0] skips the storage access, returns o_val = 0 and
//   raises o_fault with o_ready. When undefined, o_fault is tied low.

module ram_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_action,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_val,
    output logic [31:0] o_val,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    is_write;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             wdata;
    logic                    bad;
    logic                    accept;
    logic                    commit;

    logic [31:0] mem [DEPTH];

    // Address bits outside the word index are intentionally don't-care.
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:DEPTH_LOG2+2], i_addr[1:0]};

    assign accept = (state == IDLE) && ((i_action == 2'd1) || (i_action == 2'd2));
    assign commit = (state == BUSY) && (cnt == 4'd0);

    // Request capture: only data registers, no reset needed. Writes here while
    // reset is asserted are harmless because state is forced to IDLE and the
    // captured values are only consumed after a later accept.
`ifdef RAM_RESP_ALIGN_CHECK_EN
    logic misalign;

    always_ff @(posedge i_clk) begin
        if (accept) begin
            is_write <= (i_action == 2'd2);
            idx      <= i_addr[DEPTH_LOG2+1:2];
            wdata    <= i_val;
            misalign <= |i_addr[1:0];
        end
    end

    assign bad = misalign;
`else
    always_ff @(posedge i_clk) begin
        if (accept) begin
            is_write <= (i_action == 2'd2);
            idx      <= i_addr[DEPTH_LOG2+1:2];
            wdata    <= i_val;
        end
    end

    assign bad = 1'b0;
`endif

    // Storage write. commit can only be true in BUSY, so an asserted reset
    // (which forces IDLE immediately) blocks an uncommitted write.
    always_ff @(posedge i_clk) begin
        if (commit && is_write && !bad) begin
            mem[idx] <= wdata;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            o_val   <= 32'd0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b0;
                    o_fault <= 1'b0;
                    if (accept) begin
                        state  <= BUSY;
                        cnt    <= 4'(LATENCY - 1);
                        o_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= RESP;
                        o_ready <= 1'b1;
                        if (bad) begin
                            o_val   <= 32'd0;
                            o_fault <= 1'b1;
                        end else if (!is_write) begin
                            o_val <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_fault <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_fault <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_resp.sv
// Self-checking bench for ram_resp: transaction-level reference model
// (associative word array + expected latency) with directed and random requests.

module tb_ram_resp;

    localparam int DL  = 10;
    localparam int LAT = 2;

`ifdef RAM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic [1:0]  i_action;
    logic [31:0] i_addr;
    logic [31:0] i_val;
    logic [31:0] o_val;
    logic        o_ready;
    logic        o_busy;
    logic        o_fault;

    ram_resp #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_action (i_action),
        .i_addr   (i_addr),
        .i_val    (i_val),
        .o_val    (o_val),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_fault  (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [31:0]   ref_mem [int unsigned];
    logic [31:0] exp_oval;
    bit          oval_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << DL));
    endfunction

    // Issue one request and follow it to completion.
    // hold=1 keeps inputs stable; hold=0 scribbles random inputs during BUSY.
    task automatic do_req(input logic [1:0] act, input logic [31:0] addr,
                          input logic [31:0] val, input bit hold);
        int          n;
        bit          seen;
        bit          flt;
        int unsigned w;
        @(negedge i_clk);
        i_action = act;
        i_addr   = addr;
        i_val    = val;
        check("pre_busy", {31'd0, o_busy}, 32'd0);
        @(posedge i_clk);
        #1;
        if (act == 2'd0 || act == 2'd3) begin
            check("none_busy", {31'd0, o_busy}, 32'd0);
            check("none_ready", {31'd0, o_ready}, 32'd0);
            return;
        end
        flt  = ALIGN && (addr[1:0] != 2'b00);
        w    = widx(addr);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            check("busy_wait", {31'd0, o_busy}, 32'd1);
            check("ready_early", {31'd0, o_ready}, 32'd0);
            @(negedge i_clk);
            if (!hold) begin
                i_action = 2'($urandom_range(0, 3));
                i_addr   = $urandom;
                i_val    = $urandom;
            end
            @(posedge i_clk);
            #1;
            n++;
            if (o_ready) seen = 1'b1;
        end
        check("latency", n, LAT);
        if (!seen) return;
        if (act == 2'd2) begin
            if (!flt) ref_mem[w] = val;
        end else begin
            if (flt) begin
                exp_oval   = 32'd0;
                oval_known = 1'b1;
            end else if (ref_mem.exists(w)) begin
                exp_oval   = ref_mem[w];
                oval_known = 1'b1;
            end else begin
                oval_known = 1'b0;
            end
        end
        check("busy_resp", {31'd0, o_busy}, 32'd1);
        check("fault", {31'd0, o_fault}, {31'd0, flt});
        if (oval_known) check("oval", o_val, exp_oval);
        @(negedge i_clk);
        i_action = 2'd0;
        @(posedge i_clk);
        #1;
        check("ready_pulse", {31'd0, o_ready}, 32'd0);
        check("busy_idle", {31'd0, o_busy}, 32'd0);
        check("fault_clr", {31'd0, o_fault}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rcnt;
        int last;
        i_rst    = 1'b1;
        i_action = 2'd0;
        i_addr   = 32'd0;
        i_val    = 32'd0;
        #1;
        check("rst_val", o_val, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_fault", {31'd0, o_fault}, 32'd0);
        exp_oval   = 32'd0;
        oval_known = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;

        // Basic write/read
        do_req(2'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        do_req(2'd1, 32'h10, 32'h0, 1'b1);

        // Address wrap
        do_req(2'd2, 32'h4, 32'h1, 1'b1);
        do_req(2'd1, 32'h4 + (32'd4 << DL), 32'h0, 1'b1);

        // Inputs ignored after accept; NONE and reserved code
        do_req(2'd2, 32'h8, 32'h55, 1'b0);
        do_req(2'd1, 32'h8, 32'h0, 1'b0);
        do_req(2'd0, 32'h8, 32'h0, 1'b1);
        do_req(2'd3, 32'h8, 32'h0, 1'b1);

        // Reset during BUSY aborts an uncommitted write
        do_req(2'd2, 32'h20, 32'h11, 1'b1);
        @(negedge i_clk);
        i_action = 2'd2;
        i_addr   = 32'h20;
        i_val    = 32'h77;
        @(posedge i_clk);
        #1;
        check("abort_busy", {31'd0, o_busy}, 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("abort_val", o_val, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd0);
        check("abort_busy0", {31'd0, o_busy}, 32'd0);
        check("abort_fault", {31'd0, o_fault}, 32'd0);
        exp_oval   = 32'd0;
        oval_known = 1'b1;
        @(negedge i_clk);
        i_rst    = 1'b0;
        i_action = 2'd0;
        do_req(2'd1, 32'h20, 32'h0, 1'b1);

        // Misaligned accesses (fault only when alignment checking is built in)
        do_req(2'd2, 32'h10, 32'hCAFE0010, 1'b1);
        do_req(2'd1, 32'h13, 32'h0, 1'b1);
        do_req(2'd2, 32'h12, 32'h99, 1'b1);
        do_req(2'd1, 32'h10, 32'h0, 1'b1);

        // Continuously held request: one pulse every LAT+2 edges
        do_req(2'd2, 32'h30, 32'h3030A5A5, 1'b1);
        @(negedge i_clk);
        i_action = 2'd1;
        i_addr   = 32'h30;
        rcnt     = 0;
        last     = -1;
        for (int e = 1; e <= 3 * (LAT + 2); e++) begin
            @(posedge i_clk);
            #1;
            if (o_ready) begin
                rcnt++;
                if (last >= 0) check("spacing", e - last, LAT + 2);
                else           check("first_ready", e, LAT + 1);
                last = e;
            end
        end
        check("pulse_count", rcnt, 3);
        exp_oval   = 32'h3030A5A5;
        oval_known = 1'b1;
        check("b2b_val", o_val, exp_oval);
        @(negedge i_clk);
        i_action = 2'd0;
        @(posedge i_clk);
        #1;
        check("b2b_idle", {31'd0, o_busy}, 32'd0);

        // Random traffic over a small word pool with random upper/lower bits
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [1:0]  lo;
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            a  = ($urandom << (DL + 2)) | (32'($urandom_range(0, 7)) << 2) | {30'd0, lo};
            do_req(2'($urandom_range(0, 3)), a, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_resp.md
RAM_RESP -- requirements
Module: ram_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 Parameter LATENCY, default 2, wait cycles in BUSY (legal range 1..15).
REQ-003 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_action  input  2  request code: 0 NONE, 1 READ, 2 WRITE, 3 reserved (treated as NONE).
REQ-006 i_addr  input  32  byte address of request.
REQ-007 i_val  input  32  write data.
REQ-008 o_val  output  32  read data, registered.
REQ-009 o_ready  output  1  one-cycle response strobe.
REQ-010 o_busy  output  1  high whenever state is not IDLE; core stalls run on it.
REQ-011 o_fault  output  1  misaligned-access flag, qualified by o_ready.

Function
REQ-012 FSM states IDLE, BUSY, RESP; single 32-bit-wide storage array of 2^DEPTH_LOG2 words.
REQ-013 IDLE: action READ or WRITE at a rising edge -> latch action, addr, val; counter <= LATENCY-1; go BUSY.
REQ-014 IDLE with action NONE or 3 -> stay IDLE; no storage access.
REQ-015 BUSY: counter != 0 -> decrement; counter == 0 -> commit access at that edge, go RESP.
REQ-016 Commit WRITE: store latched val at word index addr[DEPTH_LOG2+1:2]; o_val unchanged.
REQ-017 Commit READ: o_val <= word at latched index; data reflects all earlier committed writes.
REQ-018 Address bits above DEPTH_LOG2+1 ignored (address wraps modulo memory size).
REQ-019 RESP: o_ready = 1 for exactly one cycle; unconditional transition to IDLE at next edge.
REQ-020 Inputs are ignored in BUSY and RESP; changes to i_action/i_addr/i_val after accept have no effect.
REQ-021 Accept edge to o_ready high: LATENCY+1 rising edges; with default, ready in cycle after third edge.
REQ-022 Back-to-back: a request held in the cycle after RESP is accepted as a new request; minimum spacing LATENCY+2 cycles.
REQ-023 o_val holds its last value between responses, including across WRITE responses.
REQ-024 o_fault low except as defined under Configuration.

Reset
REQ-025 i_rst asserted: state IDLE, counter 0, o_val 0, o_ready 0, o_busy 0, o_fault 0, immediately (asynchronous).
REQ-026 Reset mid-operation aborts the request; a write not yet committed shall not modify storage.
REQ-027 Storage contents are not cleared by reset.

Configuration
REQ-028 Macro RAM_RESP_ALIGN_CHECK_EN defined: latched addr[1:0] != 0 -> no storage access at commit, o_val <= 0, o_fault = 1 during the RESP cycle; timing unchanged.
REQ-029 Macro undefined: addr[1:0] ignored, access proceeds to the word index, o_fault tied 0.

Verification
REQ-030 Reset then WRITE addr 0x10 val 0xDEADBEEF, held until ready -> o_ready high 3 edges after accept, o_busy high during BUSY and RESP; then READ 0x10 -> o_val 0xDEADBEEF with o_ready.
REQ-031 WRITE 0x4 val 0x1, then READ 0x4 + (4 << DEPTH_LOG2) (= 0x1004 at default) -> o_val 0x1 (wrap).
REQ-032 Accept WRITE 0x8 val 0x55, change i_val to 0xAA during BUSY -> READ 0x8 returns 0x55; NONE and action 3 in IDLE -> o_busy stays 0.
REQ-033 Assert i_rst during BUSY of WRITE 0x20 val 0x77 (prior contents 0x11) -> outputs 0 at once; READ 0x20 returns 0x11.
REQ-034 With RAM_RESP_ALIGN_CHECK_EN: READ 0x13 -> o_ready and o_fault high together, o_val 0; WRITE 0x12 leaves word 0x10 unchanged; without macro READ 0x13 returns word 0x10, o_fault 0.
REQ-035 Requests held continuously -> accepts spaced exactly LATENCY+2 cycles, one o_ready pulse per request.
